// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the RAM-port arbiter.
//   state_t     - arbiter FSM states
//   gnt_t       - grant encoding (GNT_NONE / GNT_IF / GNT_LS)
//   STARVE_W    - width of the fetch starvation counter
//   LAT_W       - width of the read latency counter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef logic [1:0] gnt_t;

    localparam gnt_t GNT_NONE = 2'd0;
    localparam gnt_t GNT_IF   = 2'd1;
    localparam gnt_t GNT_LS   = 2'd2;

    localparam int unsigned STARVE_W = 4;
    localparam int unsigned LAT_W    = 3;

endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: picks the winning requester for the shared RAM port and
// tracks how many load/store grants have been made while fetch was waiting.
//   clk, reset - clock, synchronous active-high reset
//   if_req     - fetch request pending
//   ls_req     - load/store request pending
//   grant_en   - arbiter is idle and may issue a grant this cycle
//   gnt        - combinational winner (GNT_NONE when grant_en=0 or no request)
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic ls_req,
    input  logic grant_en,
    output gnt_t gnt
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt;

    // Load/store normally wins; fetch wins when alone or once starved.
    always_comb begin
        gnt = GNT_NONE;
        if (grant_en) begin
            if (if_req && (!ls_req || starve_cnt == LIMIT))
                gnt = GNT_IF;
            else if (ls_req)
                gnt = GNT_LS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_en) begin
            if (!if_req || gnt == GNT_IF)
                starve_cnt <= '0;
            else if (gnt == GNT_LS && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single RAM port between instruction fetch and
// load/store. Stores take one cycle on the RAM, reads wait READ_LATENCY
// cycles before capturing data_i; each transaction ends with a one-cycle ack
// to the granted requester only. All outputs are registered.
//   if_req_i/if_addr_i             - fetch request and address
//   if_ack_o/if_rdata_o            - fetch completion pulse and fetched word
//   ls_req_i/ls_we_i/ls_addr_i/ls_wdata_i - load/store request
//   ls_ack_o/ls_rdata_o            - load/store completion pulse and loaded word
//   we_o/addr_o/data_o/data_i      - RAM port
//   busy_o                         - transaction in progress (state != IDLE)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_ack_o,
    output logic [31:0] ls_rdata_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    output logic        busy_o
);

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

    state_t           state;
    gnt_t             owner;
    gnt_t             gnt;
    logic [LAT_W-1:0] lat_cnt;

    mem_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req_i),
        .ls_req   (ls_req_i),
        .grant_en (state == IDLE),
        .gnt      (gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= GNT_NONE;
            lat_cnt    <= '0;
            we_o       <= 1'b0;
            addr_o     <= '0;
            data_o     <= '0;
            if_ack_o   <= 1'b0;
            ls_ack_o   <= 1'b0;
            if_rdata_o <= '0;
            ls_rdata_o <= '0;
            busy_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    we_o    <= 1'b0;
                    lat_cnt <= '0;
                    case (gnt)
                        GNT_IF: begin
                            addr_o <= if_addr_i;
                            owner  <= GNT_IF;
                            busy_o <= 1'b1;
                            state  <= READ;
                        end
                        GNT_LS: begin
                            addr_o <= ls_addr_i;
                            owner  <= GNT_LS;
                            busy_o <= 1'b1;
                            if (ls_we_i) begin
                                // Store completes in the WRITE cycle itself,
                                // so we_o and the ack are raised together.
                                data_o   <= ls_wdata_i;
                                we_o     <= 1'b1;
                                ls_ack_o <= 1'b1;
                                state    <= WRITE;
                            end else begin
                                state <= READ;
                            end
                        end
                        default: ;
                    endcase
                end
                WRITE: begin
                    we_o     <= 1'b0;
                    ls_ack_o <= 1'b0;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
                READ: begin
                    if (lat_cnt == LAT_LAST) begin
                        if (owner == GNT_IF) begin
                            if_rdata_o <= data_i;
                            if_ack_o   <= 1'b1;
                        end else begin
                            ls_rdata_o <= data_i;
                            ls_ack_o   <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if_ack_o <= 1'b0;
                    ls_ack_o <= 1'b0;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk;
    logic        reset;

    // Instance with READ_LATENCY=1
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic        if_ack, ls_ack, we, busy;
    logic [31:0] if_rdata, ls_rdata, addr, dout, din;

    // Instance with READ_LATENCY=3 (fetch only)
    logic        if_req3, ls_req3, ls_we3;
    logic [31:0] if_addr3, ls_addr3, ls_wdata3;
    logic        if_ack3, ls_ack3, we3, busy3;
    logic [31:0] if_rdata3, ls_rdata3, addr3, dout3, din3;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .reset(reset),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
        .ls_ack_o(ls_ack), .ls_rdata_o(ls_rdata),
        .we_o(we), .addr_o(addr), .data_o(dout), .data_i(din), .busy_o(busy)
    );

    mem_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(4)) u_dut3 (
        .clk(clk), .reset(reset),
        .if_req_i(if_req3), .if_addr_i(if_addr3), .if_ack_o(if_ack3), .if_rdata_o(if_rdata3),
        .ls_req_i(ls_req3), .ls_we_i(ls_we3), .ls_addr_i(ls_addr3), .ls_wdata_i(ls_wdata3),
        .ls_ack_o(ls_ack3), .ls_rdata_o(ls_rdata3),
        .we_o(we3), .addr_o(addr3), .data_o(dout3), .data_i(din3), .busy_o(busy3)
    );

    // RAM contents: 0x100 holds 0xDEADBEEF, every other word is {C0DE, addr[15:0]}.
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {16'hC0DE, a[15:0]};
    endfunction

    always_comb din  = ram_word(addr);
    always_comb din3 = ram_word(addr3);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        logic seq [10];
        logic [31:0] saved;

        reset = 1'b1;
        if_req = 0; ls_req = 0; ls_we = 0; if_addr = '0; ls_addr = '0; ls_wdata = '0;
        if_req3 = 0; ls_req3 = 0; ls_we3 = 0; if_addr3 = '0; ls_addr3 = '0; ls_wdata3 = '0;
        repeat (3) step();

        // Reset state
        check("rst_we", {31'b0, we}, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_data", dout, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_acks", {30'b0, if_ack, ls_ack}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_ls_rdata", ls_rdata, 32'd0);
        check("rst_busy3", {31'b0, busy3}, 32'd0);
        reset = 1'b0;
        step();

        // Fetch read, READ_LATENCY=1
        if_req = 1; if_addr = 32'h100;
        step();                                  // T+1
        check("f_addr", addr, 32'h100);
        check("f_busy", {31'b0, busy}, 32'd1);
        check("f_we", {31'b0, we}, 32'd0);
        check("f_ack_early", {31'b0, if_ack}, 32'd0);
        step();                                  // T+2
        check("f_ack", {31'b0, if_ack}, 32'd1);
        check("f_rdata", if_rdata, 32'hDEADBEEF);
        check("f_ls_ack", {31'b0, ls_ack}, 32'd0);
        if_req = 0;
        step();                                  // T+3
        check("f_ack_pulse", {31'b0, if_ack}, 32'd0);
        check("f_idle", {31'b0, busy}, 32'd0);

        // Store
        ls_req = 1; ls_we = 1; ls_addr = 32'h200; ls_wdata = 32'h12345678;
        step();                                  // T+1
        check("s_we", {31'b0, we}, 32'd1);
        check("s_addr", addr, 32'h200);
        check("s_data", dout, 32'h12345678);
        check("s_ack", {31'b0, ls_ack}, 32'd1);
        check("s_if_ack", {31'b0, if_ack}, 32'd0);
        ls_req = 0; ls_we = 0;
        step();                                  // T+2
        check("s_we_off", {31'b0, we}, 32'd0);
        check("s_ack_off", {31'b0, ls_ack}, 32'd0);
        check("s_idle", {31'b0, busy}, 32'd0);

        // Both requesters held: 4 load grants, then 1 fetch, repeating
        if_req = 1; if_addr = 32'h104;
        ls_req = 1; ls_we = 0; ls_addr = 32'h300;
        n = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            step();
            if (if_ack || ls_ack) begin
                check("st_ack_excl", {31'b0, if_ack & ls_ack}, 32'd0);
                seq[n] = if_ack;
                if (if_ack) check("st_if_rdata", if_rdata, 32'hC0DE0104);
                else        check("st_ls_rdata", ls_rdata, 32'hC0DE0300);
                n++;
                if (n == 10) begin
                    if_req = 0;
                    ls_req = 0;
                end
            end
        end
        check("st_count", n, 32'd10);
        for (int i = 0; i < n; i++)
            check($sformatf("st_winner%0d", i), {31'b0, seq[i]}, (i % 5 == 4) ? 32'd1 : 32'd0);
        step();

        // Load arriving while a fetch is in progress
        if_req = 1; if_addr = 32'h108;
        step();                                  // T+1 READ (fetch)
        ls_req = 1; ls_we = 0; ls_addr = 32'h400;
        step();                                  // T+2 RESP (fetch)
        check("lb_if_ack", {31'b0, if_ack}, 32'd1);
        check("lb_ls_ack", {31'b0, ls_ack}, 32'd0);
        check("lb_addr_held", addr, 32'h108);
        check("lb_if_rdata", if_rdata, 32'hC0DE0108);
        saved = if_rdata;
        if_req = 0;
        step();                                  // T+3 IDLE, load granted here
        check("lb_idle", {31'b0, busy}, 32'd0);
        step();                                  // T+4 READ (load)
        check("lb_addr", addr, 32'h400);
        check("lb_busy", {31'b0, busy}, 32'd1);
        step();                                  // T+5 RESP (load)
        check("lb_ls_ack2", {31'b0, ls_ack}, 32'd1);
        check("lb_ls_rdata", ls_rdata, 32'hC0DE0400);
        check("lb_if_ack2", {31'b0, if_ack}, 32'd0);
        check("lb_if_rdata_keep", if_rdata, saved);
        ls_req = 0;
        step();

        // Reset during READ, READ_LATENCY=3
        if_req3 = 1; if_addr3 = 32'h500;
        step();                                  // T+1 READ
        check("r_busy", {31'b0, busy3}, 32'd1);
        check("r_addr", addr3, 32'h500);
        step();                                  // T+2 READ
        reset = 1; if_req3 = 0;
        step();                                  // T+3, after reset edge
        check("r_we", {31'b0, we3}, 32'd0);
        check("r_addr0", addr3, 32'd0);
        check("r_data0", dout3, 32'd0);
        check("r_busy0", {31'b0, busy3}, 32'd0);
        check("r_acks0", {30'b0, if_ack3, ls_ack3}, 32'd0);
        check("r_rdata0", if_rdata3, 32'd0);
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("r_no_ack", {31'b0, if_ack3}, 32'd0);
        end

        // New fetch after reset completes with 4-cycle latency
        if_req3 = 1; if_addr3 = 32'h504;
        step();                                  // T+1
        check("n_addr", addr3, 32'h504);
        check("n_busy", {31'b0, busy3}, 32'd1);
        step();                                  // T+2
        check("n_ack_t2", {31'b0, if_ack3}, 32'd0);
        step();                                  // T+3
        check("n_ack_t3", {31'b0, if_ack3}, 32'd0);
        step();                                  // T+4 RESP
        check("n_ack", {31'b0, if_ack3}, 32'd1);
        check("n_rdata", if_rdata3, 32'hC0DE0504);
        check("n_ls_ack", {31'b0, ls_ack3}, 32'd0);
        if_req3 = 0;
        step();
        check("n_ack_off", {31'b0, if_ack3}, 32'd0);
        check("n_idle", {31'b0, busy3}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the CPU's single RAM port (we_o/addr_o/data_o/data_i) between the instruction-fetch requester and the load/store requester.
- Picks one requester per transaction, sequences the RAM access (single-cycle write, fixed-latency read), captures read data and returns a one-cycle ack.
- Sits between the control/fetch units and the RAM pins of riscv_cpu.

Parameters:
- READ_LATENCY, 1, cycles from first cycle addr_o is driven to valid data_i (legal range 1..7).
- STARVE_LIMIT, 4, consecutive load/store grants made while fetch is waiting before fetch is forced to win (legal range 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch read request; held until if_ack_o
- if_addr_i  in  32  fetch address; stable while if_req_i=1
- if_ack_o  out  1  one-cycle pulse: fetch transaction complete, if_rdata_o valid
- if_rdata_o  out  32  fetched word
- ls_req_i  in  1  load/store request; held until ls_ack_o
- ls_we_i  in  1  1=store, 0=load; stable while ls_req_i=1
- ls_addr_i  in  32  load/store address
- ls_wdata_i  in  32  store data
- ls_ack_o  out  1  one-cycle pulse: load/store complete, ls_rdata_o valid for loads
- ls_rdata_o  out  32  loaded word
- we_o  out  1  RAM write enable
- addr_o  out  32  RAM address
- data_o  out  32  RAM write data
- data_i  in  32  RAM read data
- busy_o  out  1  1 when state != IDLE

Behaviour:
- Reset (sampled at clk edge): state=IDLE, all outputs 0, starve_cnt=0, latency counter=0. Reset mid-transaction aborts it: no ack is issued, and we_o is 0 from the next cycle.
- FSM states: IDLE, WRITE, READ, RESP. All outputs are registered.
- IDLE (cycle T), no request: stay; we_o=0; addr_o/data_o hold their last values.
- IDLE (cycle T), request present:
  - Pick the winner.
  - Load addr_o from the winner's address, and data_o from ls_wdata_i when the winner is a store.
  - Go to WRITE (store) or READ (load or fetch).
- Arbitration:
  - Only ls_req_i: ls wins. Only if_req_i: if wins.
  - Both: ls wins unless starve_cnt==STARVE_LIMIT, in which case if wins.
  - starve_cnt increments when ls is granted while if_req_i=1. It clears when if is granted, or in any IDLE cycle with if_req_i=0. It saturates at STARVE_LIMIT.
- WRITE (cycle T+1): we_o=1 for exactly this cycle; ls_ack_o=1 this cycle; next state IDLE. Store latency from grant: 1 cycle.
- READ (cycles T+1 .. T+READ_LATENCY):
  - we_o=0; addr_o held.
  - At the edge ending cycle T+READ_LATENCY, capture data_i into the winner's rdata register, then go to RESP.
- RESP (cycle T+READ_LATENCY+1): the winner's ack=1 and its rdata is valid; next state IDLE. Default read latency from grant is 2 cycles.
- Ack is a single-cycle pulse, only to the granted requester. The other requester's ack stays 0.
- Requests arriving in non-IDLE cycles are not sampled; they wait for IDLE.
- The requester drops or renews req the cycle after ack. The IDLE cycle after ack samples afresh, so a renewed req is a new transaction.
- Minimum spacing between grants: store 2 cycles, read READ_LATENCY+2 cycles.
- if_rdata_o and ls_rdata_o hold their last captured value until the next read for that requester. They are meaningful only in the ack cycle.
- Width rules: addresses and data pass through unmodified (32 bit, no alignment checks). starve_cnt is 4 bits. The latency counter is 3 bits.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, WRITE, READ, RESP); grant encoding constants GNT_NONE/GNT_IF/GNT_LS; localparam widths for starve_cnt and the latency counter.
- One sub-module, mem_arb_select: combinational winner selection plus the starve_cnt register, with inputs if_req, ls_req, grant_en and output gnt. Everything else lives in mem_arbiter.

Test Plan:
- Fetch read, READ_LATENCY=1, if_addr_i=0x100, RAM returns 0xDEADBEEF one cycle after addr -> addr_o=0x100 at T+1; if_ack_o=1 with if_rdata_o=0xDEADBEEF at T+2; ls_ack_o stays 0.
- Store ls_we_i=1, ls_addr_i=0x200, ls_wdata_i=0x12345678 -> at T+1: we_o=1, addr_o=0x200, data_o=0x12345678 and ls_ack_o=1; we_o=0 at T+2.
- if_req_i and ls_req_i held continuously, STARVE_LIMIT=4 -> 4 ls grants, then 1 if grant, then the pattern repeats; no more than 4 consecutive ls acks while fetch waits.
- Reset asserted during READ with READ_LATENCY=3 -> no ack pulse; all outputs 0 and busy_o=0 the cycle after reset. A new fetch after reset completes normally.
- Load issued while busy with a fetch -> load is not granted until the IDLE cycle after if_ack_o; load data routed only to ls_rdata_o; if_rdata_o unchanged.
